alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
Sequencing controller for the 2-of-3 sensor alarm datapath (door/window/presence). It synchronizes and debounces the three raw sensor inputs and forms the majority vote internally. An arm/disarm state machine with exit delay, entry delay and a timed siren drives the alarm LED/siren outputs. It sits between the board switches/sensors and the LED outputs.

Parameters:
TICK_DIV, 50_000_000, clk cycles per timer tick (1 s at 50 MHz); min 2
DEB_CYCLES, 500_000, consecutive stable cycles required to accept a sensor change; min 1
EXIT_TICKS, 10, ticks from arm to armed; min 1
ENTRY_TICKS, 5, ticks from trigger to siren; min 1
SIREN_TICKS, 30, ticks siren stays on before auto re-arm; min 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sensor_a  in  1  door sensor, raw, asynchronous
sensor_b  in  1  window sensor, raw, asynchronous
sensor_c  in  1  presence sensor, raw, asynchronous
arm  in  1  single-cycle pulse, synchronous to clk
disarm  in  1  single-cycle pulse, synchronous to clk
state  out  3  DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4
siren  out  1  high in ALARM
armed_led  out  1  high in ARMED, ENTRY or ALARM
beeper  out  1  high in EXIT or ENTRY
vote  out  1  registered majority of the debounced sensors (diagnostic)
alarm_count  out  8  number of entries into ALARM, saturating at 255

Behaviour:
- Reset (async, rst=1): state=DISARMED. Sync flops, debounced values, debounce counters, tick prescaler, delay timer, alarm_count and vote are 0. All outputs read 0, with state=0.
- Sync: each sensor passes through a 2-FF synchronizer.
- Debounce (per sensor): counter of consecutive cycles where the synced value != the debounced value. Any equal cycle clears it. When the count reaches DEB_CYCLES, the debounced value takes the synced value and the counter clears.
- Vote: vote <= (a&b)|(a&c)|(b&c) on the debounced values. The registered vote changes DEB_CYCLES+3 edges after a clean raw step.
- Tick: free-running counter 0..TICK_DIV-1 from reset. tick=1 for one cycle when the counter is at TICK_DIV-1, then it wraps to 0. The prescaler is never restarted by the FSM.
- Timer: loaded on a state entry. It decrements only on tick. The timed state exits on the tick that takes the timer from 1 to 0. Elapsed time is therefore between N-1 and N tick periods, since the phase is uncorrected.
- Priority within a cycle: disarm > timer expiry > vote > arm.
- FSM transitions (registered; outputs are decoded from state, so they are 0-latency relative to state):
  - DISARMED: arm -> EXIT, timer=EXIT_TICKS. Vote is ignored.
  - EXIT: disarm -> DISARMED. Expiry -> ARMED. Vote is ignored.
  - ARMED: disarm -> DISARMED. vote=1 -> ENTRY, timer=ENTRY_TICKS.
  - ENTRY: disarm -> DISARMED. Expiry -> ALARM, timer=SIREN_TICKS, alarm_count+1 (saturates at 255). vote returning to 0 does not cancel.
  - ALARM: disarm -> DISARMED. Expiry -> ARMED. If vote is still 1, the next cycle goes ARMED -> ENTRY, i.e. a new entry delay.
- arm is ignored outside DISARMED. arm and disarm in the same cycle: disarm wins, no state change from DISARMED.
- disarm on the same cycle as timer expiry: goes to DISARMED, and alarm_count is not incremented.
- Timer width is sized for max(EXIT_TICKS, ENTRY_TICKS, SIREN_TICKS). Tick counter width is clog2(TICK_DIV).
- Reset asserted mid-operation (any state, siren on) forces everything to reset values immediately. After release, the block needs a fresh arm.

Test Plan (TICK_DIV=4, DEB_CYCLES=3, EXIT_TICKS=2, ENTRY_TICKS=3, SIREN_TICKS=4):
1. Reset, then hold sensor_a=sensor_b=1 steady -> vote=1 exactly 6 edges after the step; state stays 0; siren=0, armed_led=0.
2. Debounce: sensor_a=sensor_b=1 with sensor_b glitched low for 2 cycles after acceptance -> vote stays 1. A 3-cycle low drop on sensor_b -> vote=0.
3. Full alarm path: arm pulse -> state=1, beeper=1. After 2 ticks -> state=2, armed_led=1. Raise a,c -> state=3 after the vote latency. 3 ticks later -> state=4, siren=1, alarm_count=1. 4 ticks later -> state=2 with sensors low.
4. Persistent trigger: as in 3 but keep a,c high through ALARM -> after siren expiry, state 4 -> 2 -> 3 on consecutive edges. The second ALARM gives alarm_count=2.
5. Disarm in each of EXIT, ARMED, ENTRY and ALARM -> state=0 on the next edge, all outputs 0. Disarm on the ENTRY-expiry cycle -> state=0 and alarm_count unchanged. arm+disarm together in DISARMED -> state stays 0.
6. Assert rst mid-ALARM and mid-tick -> siren=0, state=0, alarm_count=0 without waiting for a clock. Force 256 alarms -> alarm_count holds 255.

Source files
------------

// File: rtl/alarm_controller.sv
// alarm_controller: debounced 2-of-3 sensor vote driving an arm/exit/entry/siren state machine.
module alarm_controller #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DEB_CYCLES  = 500_000,
    parameter int EXIT_TICKS  = 10,
    parameter int ENTRY_TICKS = 5,
    parameter int SIREN_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_a,
    input  logic       sensor_b,
    input  logic       sensor_c,
    input  logic       arm,
    input  logic       disarm,
    output logic [2:0] state,
    output logic       siren,
    output logic       armed_led,
    output logic       beeper,
    output logic       vote,
    output logic [7:0] alarm_count
);
    localparam int TW   = $clog2(TICK_DIV);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int MAXT = (EXIT_TICKS > ENTRY_TICKS ? EXIT_TICKS : ENTRY_TICKS) > SIREN_TICKS
                        ? (EXIT_TICKS > ENTRY_TICKS ? EXIT_TICKS : ENTRY_TICKS) : SIREN_TICKS;
    localparam int TMW  = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync1_q, sync2_q, deb_q, deb_d;
    logic [DW-1:0]   dcnt_q [3];
    logic [DW-1:0]   dcnt_d [3];
    logic            vote_q, vote_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [TMW-1:0]  timer_q, timer_d;
    logic [7:0]      count_q, count_d;
    logic            tick, timed, expire;

    // A change is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) deb_d[i] = sync2_q[i];
                else dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    assign vote_d     = (deb_q[0] & deb_q[1]) | (deb_q[0] & deb_q[2]) | (deb_q[1] & deb_q[2]);
    assign tick       = tick_cnt_q == TW'(TICK_DIV - 1);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign timed      = state_q == EXIT || state_q == ENTRY || state_q == ALARM;
    assign expire     = tick && timed && timer_q == TMW'(1);

    always_comb begin
        state_d = state_q;
        timer_d = (tick && timer_q != '0) ? timer_q - 1'b1 : timer_q;
        count_d = count_q;
        if (disarm) state_d = DISARMED;
        else begin
            case (state_q)
                DISARMED: if (arm) begin
                    state_d = EXIT;
                    timer_d = TMW'(EXIT_TICKS);
                end
                EXIT:     if (expire) state_d = ARMED;
                ARMED:    if (vote_q) begin
                    state_d = ENTRY;
                    timer_d = TMW'(ENTRY_TICKS);
                end
                ENTRY:    if (expire) begin
                    state_d = ALARM;
                    timer_d = TMW'(SIREN_TICKS);
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 1'b1;
                end
                ALARM:    if (expire) state_d = ARMED;
                default:  state_d = DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DISARMED;
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
            vote_q     <= 1'b0;
            tick_cnt_q <= '0;
            timer_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= {sensor_c, sensor_b, sensor_a};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
            vote_q     <= vote_d;
            tick_cnt_q <= tick_cnt_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
        end
    end

    assign state       = state_q;
    assign siren       = state_q == ALARM;
    assign armed_led   = state_q == ARMED || state_q == ENTRY || state_q == ALARM;
    assign beeper      = state_q == EXIT || state_q == ENTRY;
    assign vote        = vote_q;
    assign alarm_count = count_q;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed scenarios plus random stimulus against a behavioural model.
module tb_alarm_controller;
    localparam int TD = 4, DEB = 3, EXT = 2, ENT = 3, SIR = 4;

    logic clk = 0, rst = 0, sa = 0, sb = 0, sc = 0, arm = 0, disarm = 0;
    logic [2:0] state;
    logic       siren, armed_led, beeper, vote;
    logic [7:0] alarm_count;
    int passed = 0, total = 0;

    alarm_controller #(
        .TICK_DIV(TD), .DEB_CYCLES(DEB), .EXIT_TICKS(EXT), .ENTRY_TICKS(ENT), .SIREN_TICKS(SIR)
    ) dut (
        .clk(clk), .rst(rst), .sensor_a(sa), .sensor_b(sb), .sensor_c(sc),
        .arm(arm), .disarm(disarm), .state(state), .siren(siren), .armed_led(armed_led),
        .beeper(beeper), .vote(vote), .alarm_count(alarm_count)
    );

    always #5 clk = ~clk;

    // Model state: edges since reset, sync stages, sample windows, ticks left in the timed state.
    typedef struct packed {
        int             cyc;
        logic [2:0]     s1, s2, deb;
        logic [DEB-1:0] wa, wb, wc;
        logic           vote;
        int             st;
        int             left;
        int             cnt;
    } m_t;

    m_t m;

    function automatic m_t step_model(m_t c, logic [2:0] raw, logic a, logic d);
        m_t n;
        logic tk, ex;
        n  = c;
        tk = (c.cyc % TD) == TD - 1;
        ex = tk && c.left == 1 && (c.st == 1 || c.st == 3 || c.st == 4);
        n.cyc = c.cyc + 1;
        n.s1  = raw;
        n.s2  = c.s1;
        n.wa  = DEB'({c.wa, c.s2[0]});
        n.wb  = DEB'({c.wb, c.s2[1]});
        n.wc  = DEB'({c.wc, c.s2[2]});
        if (n.wa == {DEB{~c.deb[0]}}) n.deb[0] = ~c.deb[0];
        if (n.wb == {DEB{~c.deb[1]}}) n.deb[1] = ~c.deb[1];
        if (n.wc == {DEB{~c.deb[2]}}) n.deb[2] = ~c.deb[2];
        n.vote = (int'(c.deb[0]) + int'(c.deb[1]) + int'(c.deb[2])) >= 2;
        if (tk && c.left > 0) n.left = c.left - 1;
        if (d) n.st = 0;
        else if (ex) begin
            if (c.st == 3) begin
                n.st   = 4;
                n.left = SIR;
                n.cnt  = (c.cnt < 255) ? c.cnt + 1 : 255;
            end else n.st = 2;
        end else if (c.st == 2 && c.vote) begin
            n.st   = 3;
            n.left = ENT;
        end else if (c.st == 0 && a) begin
            n.st   = 1;
            n.left = EXT;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) m <= '0;
        else m <= step_model(m, {sc, sb, sa}, arm, disarm);

    logic [14:0] outs, exp_o;
    assign outs = {state, siren, armed_led, beeper, vote, alarm_count};
    always_comb exp_o = {m.st[2:0], m.st == 4, m.st >= 2, m.st == 1 || m.st == 3, m.vote, 8'(m.cnt)};

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] t, input int maxc, output int n, output logic [2:0] prev);
        n = 0;
        prev = state;
        while (state !== t && n <= maxc) begin
            prev = state;
            step(1);
            n++;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1;
        #1;
        total++;
        if (outs !== 15'd0) $display("FAIL reset_async: got %h want 0", outs); else passed++;
        @(negedge clk) rst = 0;
        step(2);
        total++;
        if (outs !== 15'd0 || outs !== exp_o) $display("FAIL reset_idle: got %h want 0 (model %h)", outs, exp_o); else passed++;
    endtask

    task automatic test_vote_latency();
        logic [5:0] got, want;
        int bad = 0;
        sa = 1;
        sb = 1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            got  = {vote, state, siren, armed_led};
            want = {k >= 6, 3'd0, 1'b0, 1'b0};
            if (got !== want) begin
                bad++;
                $display("FAIL vote_latency edge %0d: got %b want %b", k, got, want);
            end
        end
        total++;
        if (bad == 0) passed++;
        total++;
        if (outs !== exp_o) $display("FAIL vote_latency_model: got %h want %h", outs, exp_o); else passed++;
    endtask

    task automatic test_debounce();
        int dropped = 0;
        sb = 0;
        step(2);
        sb = 1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (vote !== 1'b1) dropped++;
        end
        total++;
        if (dropped != 0) $display("FAIL glitch_filtered: vote low %0d cycles, want 0", dropped); else passed++;
        sb = 0;
        step(3);
        sb = 1;
        step(3);
        total++;
        if (vote !== 1'b0 || outs !== exp_o) $display("FAIL drop_accepted: vote %b want 0 (outs %h model %h)", vote, outs, exp_o); else passed++;
        step(10);
        total++;
        if (vote !== 1'b1) $display("FAIL drop_recovered: vote %b want 1", vote); else passed++;
        sa = 0;
        sb = 0;
        step(8);
        total++;
        if (outs !== exp_o || vote !== 1'b0) $display("FAIL debounce_clear: got %h want %h", outs, exp_o); else passed++;
    endtask

    task automatic test_alarm_path();
        int n;
        logic [2:0] p;
        arm = 1;
        step(1);
        arm = 0;
        total++;
        if ({state, beeper, armed_led, siren} !== {3'd1, 3'b100}) $display("FAIL arm_to_exit: state %0d beeper %b", state, beeper); else passed++;
        wait_state(3'd2, 20, n, p);
        total++;
        if (n < (EXT - 1) * TD + 1 || n > EXT * TD || armed_led !== 1'b1 || beeper !== 1'b0)
            $display("FAIL exit_delay: %0d cycles, want %0d..%0d, led %b", n, (EXT - 1) * TD + 1, EXT * TD, armed_led);
        else passed++;
        sa = 1;
        sc = 1;
        wait_state(3'd3, 20, n, p);
        total++;
        if (n !== 7) $display("FAIL vote_to_entry: %0d edges, want 7", n); else passed++;
        wait_state(3'd4, 20, n, p);
        total++;
        if (n < (ENT - 1) * TD + 1 || n > ENT * TD || siren !== 1'b1 || alarm_count !== 8'd1)
            $display("FAIL entry_delay: %0d cycles siren %b count %0d, want %0d..%0d 1 1", n, siren, alarm_count, (ENT - 1) * TD + 1, ENT * TD);
        else passed++;
        total++;
        if (outs !== exp_o) $display("FAIL alarm_model: got %h want %h", outs, exp_o); else passed++;
        sa = 0;
        sc = 0;
        wait_state(3'd2, 20, n, p);
        total++;
        if (n < (SIR - 1) * TD + 1 || n > SIR * TD || siren !== 1'b0)
            $display("FAIL siren_time: %0d cycles siren %b, want %0d..%0d 0", n, siren, (SIR - 1) * TD + 1, SIR * TD);
        else passed++;
        step(8);
        total++;
        if (state !== 3'd2 || outs !== exp_o) $display("FAIL rearmed_idle: got %h want %h", outs, exp_o); else passed++;
    endtask

    task automatic test_persistent();
        int n;
        logic [2:0] p;
        sa = 1;
        sc = 1;
        wait_state(3'd3, 20, n, p);
        wait_state(3'd4, 20, n, p);
        total++;
        if (alarm_count !== 8'd2) $display("FAIL second_alarm_count: got %0d want 2", alarm_count); else passed++;
        wait_state(3'd2, 20, n, p);
        step(1);
        total++;
        if (p !== 3'd4 || state !== 3'd3) $display("FAIL retrigger: prev %0d now %0d, want 4 then 3", p, state); else passed++;
        wait_state(3'd4, 20, n, p);
        total++;
        if (alarm_count !== 8'd3 || outs !== exp_o) $display("FAIL third_alarm: got %h want %h", outs, exp_o); else passed++;
        disarm = 1;
        step(1);
        disarm = 0;
        sa = 0;
        sc = 0;
        step(8);
    endtask

    task automatic test_disarm();
        int n;
        logic [2:0] p;
        int c0;
        logic found;
        for (int t = 1; t <= 4; t++) begin
            arm = 1;
            step(1);
            arm = 0;
            if (t >= 2) wait_state(3'd2, 20, n, p);
            if (t >= 3) begin
                sa = 1;
                sc = 1;
                wait_state(3'd3, 20, n, p);
                sa = 0;
                sc = 0;
            end
            if (t == 4) wait_state(3'd4, 20, n, p);
            total++;
            if (state !== 3'(t)) $display("FAIL disarm_setup_%0d: state %0d want %0d", t, state, t); else passed++;
            disarm = 1;
            step(1);
            disarm = 0;
            total++;
            if ({state, siren, armed_led, beeper} !== 6'd0 || outs !== exp_o)
                $display("FAIL disarm_from_%0d: got %h want %h", t, outs, exp_o);
            else passed++;
            step(8);
        end
        arm = 1;
        step(1);
        arm = 0;
        wait_state(3'd2, 20, n, p);
        sa = 1;
        sc = 1;
        wait_state(3'd3, 20, n, p);
        sa = 0;
        sc = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m.st == 3 && m.left == 1 && (m.cyc % TD) == TD - 1) found = 1;
            else step(1);
        end
        c0 = m.cnt;
        disarm = 1;
        step(1);
        disarm = 0;
        total++;
        if (!found || state !== 3'd0 || alarm_count !== 8'(c0))
            $display("FAIL disarm_at_expiry: found %b state %0d count %0d, want 1 0 %0d", found, state, alarm_count, c0);
        else passed++;
        arm = 1;
        disarm = 1;
        step(1);
        arm = 0;
        disarm = 0;
        step(3);
        total++;
        if (state !== 3'd0 || outs !== exp_o) $display("FAIL arm_and_disarm: state %0d want 0", state); else passed++;
        step(8);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: sa = ~sa;
                    1: sb = ~sb;
                    default: sc = ~sc;
                endcase
            end
            arm    = $urandom_range(0, 15) == 0;
            disarm = $urandom_range(0, 63) == 0;
            step(1);
            total++;
            if (outs !== exp_o) begin
                bad++;
                if (bad <= 10) $display("FAIL random cycle %0d: got %h want %h", k, outs, exp_o);
            end else passed++;
        end
        arm = 0;
        disarm = 1;
        step(1);
        disarm = 0;
        sa = 0;
        sb = 0;
        sc = 0;
        step(8);
    endtask

    task automatic test_reset_mid();
        int n;
        logic [2:0] p;
        arm = 1;
        step(1);
        arm = 0;
        wait_state(3'd2, 20, n, p);
        sa = 1;
        sc = 1;
        wait_state(3'd3, 20, n, p);
        wait_state(3'd4, 20, n, p);
        step(1);
        #2 rst = 1;
        #1;
        total++;
        if ({state, siren, alarm_count} !== 12'd0 || outs !== exp_o) $display("FAIL reset_mid_alarm: got %h want 0", outs); else passed++;
        @(negedge clk) rst = 0;
        step(10);
        total++;
        if (state !== 3'd0 || outs !== exp_o) $display("FAIL needs_fresh_arm: got %h want %h", outs, exp_o); else passed++;
    endtask

    task automatic test_saturation();
        int n;
        logic [2:0] p;
        logic hit;
        arm = 1;
        step(1);
        arm = 0;
        hit = 0;
        for (int k = 0; k < 256 * 40 && !hit; k++) begin
            if (alarm_count === 8'd255) hit = 1;
            else step(1);
        end
        wait_state(3'd3, 40, n, p);
        wait_state(3'd4, 20, n, p);
        total++;
        if (!hit || alarm_count !== 8'd255 || m.cnt != 255 || state !== 3'd4)
            $display("FAIL saturate: reached %b count %0d state %0d, want 1 255 4", hit, alarm_count, state);
        else passed++;
        disarm = 1;
        step(1);
        disarm = 0;
        total++;
        if (outs !== exp_o || alarm_count !== 8'd255) $display("FAIL saturate_hold: got %h want %h", outs, exp_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_vote_latency();
        test_debounce();
        test_alarm_path();
        test_persistent();
        test_disarm();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
